// File: rtl/conv_window_gather.sv
// Pulls 3-pixel vertical columns from the line-buffer router and assembles them into
// 3x3 windows with centre coordinates, pacing one frame per enable.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for enable_i; no columns requested
//   RUN   | requesting and accepting columns, emitting windows
//   DRAIN | last column accepted; waiting for the final window to be taken
module conv_window_gather #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PW     = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       enable_i,
    input  logic [3*PW-1:0]            column_i,
    input  logic                       v_i,
    output logic                       request_o,
    output logic [9*PW-1:0]            window_o,
    output logic                       win_v_o,
    input  logic                       win_ready_i,
    output logic [$clog2(WIDTH)-1:0]   win_col_o,
    output logic [$clog2(HEIGHT)-1:0]  win_row_o,
    output logic                       frame_done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic [3*PW-1:0] s0;
    logic [3*PW-1:0] s1;
    logic [9*PW-1:0] win_next;
    logic            accept;
    logic            emit;
    logic            last_col;
    logic            last_row;

    // A pending window blocks new columns unless it is being taken this cycle.
    assign request_o    = (state_q == RUN) && (!win_v_o || win_ready_i);
    assign accept       = request_o && v_i;
    assign last_col     = (col_cnt == COL_LAST);
    assign last_row     = (row_cnt == ROW_LAST);
    assign emit         = accept && (col_cnt >= CW'(2));
    assign frame_done_o = (state_q == DRAIN) && win_v_o && win_ready_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && last_col && last_row) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (win_v_o && win_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            col_cnt <= '0;
            row_cnt <= '0;
            s0      <= '0;
            s1      <= '0;
        end else if (accept) begin
            s0 <= s1;
            s1 <= column_i;
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end else if (frame_done_o) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end
    end

    // Column c=0 is the oldest (s0), c=2 the column arriving now.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[(r*3+0)*PW +: PW] = s0[r*PW +: PW];
            win_next[(r*3+1)*PW +: PW] = s1[r*PW +: PW];
            win_next[(r*3+2)*PW +: PW] = column_i[r*PW +: PW];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            win_v_o   <= 1'b0;
            window_o  <= '0;
            win_col_o <= '0;
            win_row_o <= '0;
        end else if (emit) begin
            win_v_o   <= 1'b1;
            window_o  <= win_next;
            win_col_o <= col_cnt - CW'(1);
            win_row_o <= row_cnt + RW'(1);
        end else if (win_ready_i) begin
            win_v_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gather.sv
// Directed bench for conv_window_gather on a 4x4 frame: four windows per frame,
// checked against hand-derived contents and coordinates.
module tb_conv_window_gather;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 4;
    localparam int PW     = 8;

    logic            clk_i       = 1'b0;
    logic            reset_i     = 1'b0;
    logic            enable_i    = 1'b0;
    logic [3*PW-1:0] column_i    = '0;
    logic            v_i         = 1'b0;
    logic            win_ready_i = 1'b0;
    logic            request_o;
    logic [9*PW-1:0] window_o;
    logic            win_v_o;
    logic [1:0]      win_col_o;
    logic [1:0]      win_row_o;
    logic            frame_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9*PW-1:0] got_win [8];
    int              got_col [8];
    int              got_row [8];
    bit              got_done[8];
    bit              emit_after[16];
    int              nwin, ndone, nacc, stall_bad, stall_cnt, post_bad;
    bit              aborted;
    logic            rs_req, rs_wv, rs_fd;
    logic [9*PW-1:0] rs_win;
    logic [1:0]      rs_col, rs_row;

    conv_window_gather #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PW(PW)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .column_i     (column_i),
        .v_i          (v_i),
        .request_o    (request_o),
        .window_o     (window_o),
        .win_v_o      (win_v_o),
        .win_ready_i  (win_ready_i),
        .win_col_o    (win_col_o),
        .win_row_o    (win_row_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3*PW-1:0] col_of(input int n);
        logic [3*PW-1:0] c;
        c[PW-1:0]      = PW'(n);
        c[2*PW-1:PW]   = PW'(n + 16);
        c[3*PW-1:2*PW] = PW'(n + 32);
        return c;
    endfunction

    // Windows start at columns 0,1 (row-triplet 0) and 4,5 (row-triplet 1).
    function automatic logic [9*PW-1:0] exp_win(input int k);
        logic [9*PW-1:0] w;
        int n0;
        n0 = (k < 2) ? k : k + 2;
        w  = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*PW +: PW] = PW'(n0 + c + 16*r);
        return w;
    endfunction

    task automatic start_frame(output logic req_seen);
        v_i = 1'b0;
        win_ready_i = 1'b1;
        @(negedge clk_i);
        enable_i = 1'b1;
        @(negedge clk_i);
        enable_i = 1'b0;
        #1;
        req_seen = request_o;
    endtask

    task automatic run_frame(input bit v_toggle, input bit en_toggle, input int stall_len,
                             input int abort_at, input int budget);
        int n, prev_n, stall_left;
        bit acc, acc_prev, seen_v, fin;
        logic [9*PW-1:0] held;
        n = 0; prev_n = 0; stall_left = 0;
        acc_prev = 0; seen_v = 0; fin = 0; held = '0;
        nwin = 0; ndone = 0; nacc = 0; stall_bad = 0; stall_cnt = 0; aborted = 0;
        for (int i = 0; i < 16; i++) emit_after[i] = 0;
        for (int i = 0; i < 8; i++) begin
            got_win[i] = '0; got_col[i] = -1; got_row[i] = -1; got_done[i] = 0;
        end
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk_i);
            if (win_v_o && !seen_v) begin
                seen_v = 1; stall_left = stall_len; held = window_o;
            end
            win_ready_i = (stall_left == 0);
            v_i         = v_toggle ? (cyc % 2 == 0) : 1'b1;
            enable_i    = en_toggle && (cyc % 2 == 1);
            column_i    = col_of(n < 8 ? n : 7);
            #1;
            if (stall_left > 0) begin
                stall_cnt++;
                if (request_o !== 1'b0 || window_o !== held || win_v_o !== 1'b1) stall_bad++;
                stall_left--;
            end
            if (acc_prev && prev_n < 16) emit_after[prev_n] = win_v_o;
            if (win_v_o && win_ready_i && nwin < 8) begin
                got_win[nwin]  = window_o;
                got_col[nwin]  = int'(win_col_o);
                got_row[nwin]  = int'(win_row_o);
                got_done[nwin] = frame_done_o;
                nwin++;
            end
            if (frame_done_o) begin
                ndone++; fin = 1;
            end
            acc = request_o && v_i;
            if (abort_at > 0 && nwin == abort_at && !aborted) begin
                reset_i = 1'b0;
                #1;
                rs_req = request_o; rs_wv = win_v_o; rs_fd = frame_done_o;
                rs_win = window_o; rs_col = win_col_o; rs_row = win_row_o;
                aborted = 1; fin = 1; acc = 0;
            end
            acc_prev = acc; prev_n = n;
            if (acc) begin
                nacc++; n++;
            end
        end
        enable_i = 1'b0;
    endtask

    task automatic post_idle();
        post_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1;
            if (request_o !== 1'b0 || win_v_o !== 1'b0 || frame_done_o !== 1'b0) post_bad++;
        end
    endtask

    task automatic test_reset();
        v_i = 1'b1; win_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (request_o !== 1'b0 || win_v_o !== 1'b0 || frame_done_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_ctrl: req=%b wv=%b fd=%b expected 0 0 0", request_o, win_v_o, frame_done_o);
        end
        n_cmp++;
        if (window_o !== '0 || win_col_o !== 2'd0 || win_row_o !== 2'd0) begin
            n_bad++; $display("FAIL reset_data: win=%h col=%0d row=%0d expected zeros", window_o, win_col_o, win_row_o);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        post_idle();
        n_cmp++;
        if (post_bad !== 0) begin
            n_bad++; $display("FAIL reset_idle: %0d active cycles, expected 0", post_bad);
        end
    endtask

    task automatic test_basic();
        logic req;
        start_frame(req);
        n_cmp++;
        if (req !== 1'b1) begin
            n_bad++; $display("FAIL basic_req_after_en: got %b expected 1", req);
        end
        run_frame(0, 0, 0, 0, 200);
        n_cmp++;
        if (nwin !== 4) begin
            n_bad++; $display("FAIL basic_nwin: got %0d expected 4", nwin);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_win[k] !== exp_win(k) || got_col[k] !== 1 + k % 2 || got_row[k] !== 1 + k / 2) begin
                n_bad++;
                $display("FAIL basic_win%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", k, got_win[k],
                         got_col[k], got_row[k], exp_win(k), 1 + k % 2, 1 + k / 2);
            end
        end
        n_cmp++;
        if (nacc !== 8) begin
            n_bad++; $display("FAIL basic_accepts: got %0d expected 8", nacc);
        end
        n_cmp++;
        if (ndone !== 1 || got_done[3] !== 1'b1 || got_done[0] || got_done[1] || got_done[2]) begin
            n_bad++; $display("FAIL basic_done: pulses=%0d with_take=%b%b%b%b expected 1 with 1000",
                              ndone, got_done[3], got_done[2], got_done[1], got_done[0]);
        end
        post_idle();
        n_cmp++;
        if (post_bad !== 0) begin
            n_bad++; $display("FAIL basic_post_idle: %0d active cycles, expected 0", post_bad);
        end
    endtask

    task automatic test_backpressure();
        logic req;
        start_frame(req);
        run_frame(0, 0, 5, 0, 200);
        n_cmp++;
        if (stall_cnt !== 5 || stall_bad !== 0) begin
            n_bad++; $display("FAIL bp_hold: stall_cycles=%0d bad=%0d expected 5 and 0", stall_cnt, stall_bad);
        end
        n_cmp++;
        if (nwin !== 4 || ndone !== 1) begin
            n_bad++; $display("FAIL bp_count: windows=%0d done=%0d expected 4 and 1", nwin, ndone);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_win[k] !== exp_win(k) || got_col[k] !== 1 + k % 2 || got_row[k] !== 1 + k / 2) begin
                n_bad++;
                $display("FAIL bp_win%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", k, got_win[k],
                         got_col[k], got_row[k], exp_win(k), 1 + k % 2, 1 + k / 2);
            end
        end
        post_idle();
    endtask

    task automatic test_v_toggle();
        logic req;
        start_frame(req);
        run_frame(1, 0, 0, 0, 400);
        n_cmp++;
        if (nwin !== 4 || ndone !== 1 || nacc !== 8) begin
            n_bad++; $display("FAIL vtog_count: windows=%0d done=%0d accepts=%0d expected 4 1 8", nwin, ndone, nacc);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_win[k] !== exp_win(k) || got_col[k] !== 1 + k % 2 || got_row[k] !== 1 + k / 2) begin
                n_bad++;
                $display("FAIL vtog_win%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", k, got_win[k],
                         got_col[k], got_row[k], exp_win(k), 1 + k % 2, 1 + k / 2);
            end
        end
        post_idle();
    endtask

    task automatic test_row_wrap();
        logic req;
        logic [9*PW-1:0] w;
        start_frame(req);
        run_frame(0, 0, 0, 0, 200);
        n_cmp++;
        if (emit_after[0] || emit_after[1] || !emit_after[2] || !emit_after[3]) begin
            n_bad++; $display("FAIL wrap_row0_emits: got %b%b%b%b (cols 3..0) expected 1100",
                              emit_after[3], emit_after[2], emit_after[1], emit_after[0]);
        end
        n_cmp++;
        if (emit_after[4] !== 1'b0 || emit_after[5] !== 1'b0) begin
            n_bad++; $display("FAIL wrap_suppress: after col4=%b col5=%b expected 0 0", emit_after[4], emit_after[5]);
        end
        n_cmp++;
        if (emit_after[6] !== 1'b1) begin
            n_bad++; $display("FAIL wrap_resume: after col6=%b expected 1", emit_after[6]);
        end
        w = got_win[2];
        n_cmp++;
        if (w[PW-1:0] !== 8'd4 || w[2*PW-1:PW] !== 8'd5 || w[3*PW-1:2*PW] !== 8'd6 ||
            got_col[2] !== 1 || got_row[2] !== 2) begin
            n_bad++; $display("FAIL wrap_window: top=%0d,%0d,%0d at (%0d,%0d) expected 4,5,6 at (1,2)",
                              w[PW-1:0], w[2*PW-1:PW], w[3*PW-1:2*PW], got_col[2], got_row[2]);
        end
        post_idle();
    endtask

    task automatic test_abort();
        logic req;
        start_frame(req);
        run_frame(0, 0, 0, 2, 200);
        n_cmp++;
        if (aborted !== 1'b1 || nwin !== 2) begin
            n_bad++; $display("FAIL abort_reached: aborted=%b windows=%0d expected 1 and 2", aborted, nwin);
        end
        n_cmp++;
        if (rs_req !== 1'b0 || rs_wv !== 1'b0 || rs_fd !== 1'b0) begin
            n_bad++; $display("FAIL abort_ctrl: req=%b wv=%b fd=%b expected 0 0 0", rs_req, rs_wv, rs_fd);
        end
        n_cmp++;
        if (rs_win !== '0 || rs_col !== 2'd0 || rs_row !== 2'd0) begin
            n_bad++; $display("FAIL abort_data: win=%h col=%0d row=%0d expected zeros", rs_win, rs_col, rs_row);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        v_i = 1'b1; win_ready_i = 1'b1;
        post_idle();
        n_cmp++;
        if (post_bad !== 0) begin
            n_bad++; $display("FAIL abort_idle: %0d active cycles, expected 0", post_bad);
        end
        start_frame(req);
        run_frame(0, 0, 0, 0, 200);
        n_cmp++;
        if (nwin !== 4 || ndone !== 1 || nacc !== 8) begin
            n_bad++; $display("FAIL abort_refresh_count: windows=%0d done=%0d accepts=%0d expected 4 1 8", nwin, ndone, nacc);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_win[k] !== exp_win(k) || got_col[k] !== 1 + k % 2 || got_row[k] !== 1 + k / 2) begin
                n_bad++;
                $display("FAIL abort_win%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", k, got_win[k],
                         got_col[k], got_row[k], exp_win(k), 1 + k % 2, 1 + k / 2);
            end
        end
        post_idle();
    endtask

    task automatic test_enable();
        logic req;
        int bad;
        bad = 0;
        enable_i = 1'b0; v_i = 1'b1; win_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            #1;
            if (request_o !== 1'b0 || win_v_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL enable_low: %0d active cycles, expected 0", bad);
        end
        start_frame(req);
        run_frame(0, 1, 0, 0, 200);
        n_cmp++;
        if (nwin !== 4 || ndone !== 1 || nacc !== 8) begin
            n_bad++; $display("FAIL enable_toggle_count: windows=%0d done=%0d accepts=%0d expected 4 1 8", nwin, ndone, nacc);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_win[k] !== exp_win(k) || got_col[k] !== 1 + k % 2 || got_row[k] !== 1 + k / 2) begin
                n_bad++;
                $display("FAIL enable_toggle_win%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", k, got_win[k],
                         got_col[k], got_row[k], exp_win(k), 1 + k % 2, 1 + k / 2);
            end
        end
        post_idle();
        n_cmp++;
        if (post_bad !== 0) begin
            n_bad++; $display("FAIL enable_toggle_post_idle: %0d active cycles, expected 0", post_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_v_toggle();
        test_row_wrap();
        test_abort();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
